// File: rtl/core_test_ctrl_if.sv
// Monitored rv32i_core buses: data-memory store port and retire stream.
// The core/harness drives them through master; the run-control monitor observes them through slave.
interface core_test_ctrl_if #(
   parameter int XLEN = 32
);
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            retire_valid;
   logic [XLEN-1:0] retire_pc;

   modport master (
      output dmem_we, dmem_addr, dmem_wdata, retire_valid, retire_pc
   );

   modport slave (
      input dmem_we, dmem_addr, dmem_wdata, retire_valid, retire_pc
   );
endinterface

// File: rtl/core_test_ctrl.sv
// Run-control and test-completion monitor for the rv32i_core harness: sequences core reset release,
// watches the tohost mailbox, detects self-loop hangs and cycle timeouts, and latches a sticky verdict.
module core_test_ctrl #(
   parameter int              XLEN           = 32,
   parameter int              RESET_CYCLES   = 4,
   parameter int              TIMEOUT_CYCLES = 100000,
   parameter int              HANG_CYCLES    = 16,
   parameter logic [31:0]     TOHOST_ADDR    = 32'h0000_1000,
   parameter int              CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   core_test_ctrl_if.slave      mon,
   output logic                 core_reset_n,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic                 hang,
   output logic [XLEN-2:0]      fail_code,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     instret_count
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int HANG_W = $clog2(HANG_CYCLES + 1) + 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [HANG_W-1:0] HANG_LIM  = HANG_W'(HANG_CYCLES);
   localparam logic [CNT_W-1:0]  TO_LIM    = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [XLEN-1:0]   MBOX_ADDR = XLEN'(TOHOST_ADDR);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT,
      S_HANG
   } state_t;

   state_t state, state_nxt;

   logic [HOLD_W-1:0] hold_cnt;
   logic [HANG_W-1:0] hang_cnt, hang_cnt_nxt;
   logic [XLEN-1:0]   last_pc;
   logic              last_pc_vld;
   logic [CNT_W-1:0]  cycle_nxt;
   logic              mbox_wr, mbox_pass, pc_repeat, hang_hit, timeout_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [HANG_W-1:0] sat_inc_hang(input logic [HANG_W-1:0] v);
      return (&v) ? v : v + HANG_W'(1);
   endfunction

   // Only odd stores to the mailbox carry a verdict; even values are progress chatter.
   assign mbox_wr     = mon.dmem_we && (mon.dmem_addr == MBOX_ADDR) && mon.dmem_wdata[0];
   assign mbox_pass   = mbox_wr && (mon.dmem_wdata == XLEN'(1));
   assign pc_repeat   = mon.retire_valid && last_pc_vld && (mon.retire_pc == last_pc);
   assign cycle_nxt   = sat_inc(cycle_count);
   assign hang_hit    = (HANG_CYCLES != 0) && (hang_cnt_nxt == HANG_LIM);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_nxt == TO_LIM);

   always_comb begin
      hang_cnt_nxt = hang_cnt;
      if (mon.retire_valid)
         hang_cnt_nxt = pc_repeat ? sat_inc_hang(hang_cnt) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_HOLD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
         S_RUN: begin
            if (mbox_pass)        state_nxt = S_PASS;
            else if (mbox_wr)     state_nxt = S_FAIL;
            else if (hang_hit)    state_nxt = S_HANG;
            else if (timeout_hit) state_nxt = S_TIMEOUT;
         end
         default: state_nxt = state;
      endcase
   end

   // Counters advance only in RUN, so the verdict cycle is counted and terminal states freeze them.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt      <= '0;
         hang_cnt      <= '0;
         last_pc       <= '0;
         last_pc_vld   <= 1'b0;
         cycle_count   <= '0;
         instret_count <= '0;
         fail_code     <= '0;
      end else if (state == S_HOLD) begin
         hold_cnt <= (state_nxt == S_RUN) ? '0 : hold_cnt + HOLD_W'(1);
      end else if (state == S_RUN) begin
         cycle_count <= cycle_nxt;
         hang_cnt    <= hang_cnt_nxt;
         if (mon.retire_valid) begin
            instret_count <= sat_inc(instret_count);
            last_pc       <= mon.retire_pc;
            last_pc_vld   <= 1'b1;
         end
         if (state_nxt == S_FAIL)
            fail_code <= mon.dmem_wdata[XLEN-1:1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         core_reset_n <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         timeout      <= 1'b0;
         hang         <= 1'b0;
      end else begin
         core_reset_n <= (state_nxt != S_HOLD);
         done         <= (state_nxt inside {S_PASS, S_FAIL, S_TIMEOUT, S_HANG});
         pass         <= (state_nxt == S_PASS);
         fail         <= (state_nxt == S_FAIL);
         timeout      <= (state_nxt == S_TIMEOUT);
         hang         <= (state_nxt == S_HANG);
      end
   end

endmodule

// File: doc/core_test_ctrl.md
# core_test_ctrl

Synthesizable run-control and test-completion monitor for the rv32i_core simulation harness. It sequences the core's reset release and watches the data-memory write port for a store to a `tohost` mailbox address. It also watches the retire stream for a self-loop hang and enforces a cycle timeout. It reports a sticky pass/fail/timeout/hang verdict with cycle and retired-instruction counts, so benches no longer rely on fixed wall-clock run lengths.

## Interface
Parameters:
- `XLEN`, 32: address/data width of the monitored store and retire buses.
- `RESET_CYCLES`, 4: cycles `core_reset_n` is held low after `reset` deasserts; minimum 1.
- `TIMEOUT_CYCLES`, 100000: RUN cycles before TIMEOUT is declared; 0 disables the timeout.
- `HANG_CYCLES`, 16: consecutive retires at an unchanged PC before HANG is declared; 0 disables hang detection.
- `TOHOST_ADDR`, 32'h0000_1000: word address of the mailbox.
- `CNT_W`, 32: width of both counters.

Ports:
- `clk`  in  1  single clock. All logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `dmem_we`  in  1  the core issues a data-memory store this cycle.
- `dmem_addr`  in  XLEN  store address.
- `dmem_wdata`  in  XLEN  store data.
- `retire_valid`  in  1  one instruction retires this cycle.
- `retire_pc`  in  XLEN  PC of the retiring instruction.
- `core_reset_n`  out  1  active-low reset driven to rv32i_core.
- `done`  out  1  a verdict has been reached; sticky.
- `pass`  out  1  `tohost` received the value 1.
- `fail`  out  1  `tohost` received an odd value other than 1.
- `timeout`  out  1  the timeout expired.
- `hang`  out  1  a self-loop was detected.
- `fail_code`  out  XLEN-1  `dmem_wdata[XLEN-1:1]` of the failing write.
- `cycle_count`  out  CNT_W  number of RUN cycles.
- `instret_count`  out  CNT_W  number of retires observed in RUN.

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT, HANG. PASS, FAIL, TIMEOUT and HANG are terminal and sticky until `reset`.
- `reset` high forces HOLD and clears all counters and flags. The hold counter is zeroed.
- HOLD: the hold counter increments each cycle while `reset` is low. After RESET_CYCLES such cycles, go to RUN.
- RUN: `cycle_count` increments every cycle. `instret_count` increments on `retire_valid`. Both counters saturate at all-ones and do not wrap.
- Mailbox write means `dmem_we` is high and `dmem_addr == TOHOST_ADDR`. A store to any other address is ignored.
  - `wdata == 1`: go to PASS.
  - `wdata[0] == 1` with any other value: go to FAIL and latch `fail_code = wdata[XLEN-1:1]`.
  - `wdata[0] == 0`: ignored, and the block stays in RUN.
- Hang: a `hang_cnt` tracks repeated retires at the same PC.
  - On `retire_valid` with `retire_pc` equal to the last retired PC, `hang_cnt` increments.
  - On a retire at a different PC, `hang_cnt` resets to 0 and the last PC is updated.
  - Cycles without a retire leave `hang_cnt` unchanged.
  - When `hang_cnt` reaches HANG_CYCLES, go to HANG.
- Timeout: if a RUN cycle brings `cycle_count` to TIMEOUT_CYCLES and no other verdict is reached that cycle, go to TIMEOUT.
- Priority when several events fall in the same cycle: mailbox write (PASS/FAIL), then HANG, then TIMEOUT.
- In terminal states `core_reset_n` stays 1, so the core keeps running. All counters and flags are frozen.
- `done` = PASS | FAIL | TIMEOUT | HANG. Exactly one verdict flag is high whenever `done` is high.

## Timing
- Every output is registered; there are no combinational input-to-output paths.
- Reset values: `core_reset_n` = 0; `done`, `pass`, `fail`, `timeout`, `hang` = 0; `fail_code`, `cycle_count`, `instret_count` = 0.
- `core_reset_n` rises at the edge ending the RESET_CYCLES-th low-`reset` cycle. That is the first RUN cycle.
- Verdict latency is 1 cycle. An event sampled at edge N makes the flags and `done` visible after edge N.
- The event cycle is included in the counts; counters freeze from edge N onward.
  - A mailbox write in the k-th RUN cycle gives `cycle_count = k`.
  - A timeout gives `cycle_count = TIMEOUT_CYCLES`.
- Asserting `reset` in any state, including mid-RUN or a terminal state, returns to HOLD at the next edge. `core_reset_n` drops at that same edge.
- Inputs are ignored in HOLD. A mailbox write during HOLD has no effect.

## Test plan
- Reset hold: `reset` high 3 cycles then low, RESET_CYCLES=4 -> `core_reset_n` stays 0 for 4 cycles after `reset` falls and rises at the 4th edge; all outputs 0 until then.
- Pass: store 0x1 to 0x1000 in RUN cycle 20 with 12 retires → `done=1`, `pass=1`, `cycle_count=20`, `instret_count=12`; outputs hold for 50 more cycles.
- Fail and filters:
  - Store 0x2 to 0x1000 → ignored.
  - Store 0x7 to 0x1004 → ignored.
  - Store 0x7 to 0x1000 → `fail=1`, `fail_code=3`.
- Timeout/hang: with TIMEOUT_CYCLES=50 and no mailbox write → `timeout=1`, `cycle_count=50`. With HANG_CYCLES=16, retire PC 0x40 repeatedly → `hang=1` after the 16th repeat. A PC change at repeat 10 restarts the count.
- Priority: mailbox 0x1 write in the same cycle as the timeout/hang trigger → `pass=1` only.
- Reset mid-run: assert `reset` in RUN cycle 30 → next edge `core_reset_n=0`, counters 0; a re-run then passes normally.
